fanari_intersection: RTL and testbench

- N-approach, sensor-actuated traffic light controller; successor of the single-approach `fanari` controller.
- Serves approaches round-robin and holds green while the served approach still has traffic, up to a maximum.
- Adds a latched pedestrian all-red walk phase and a flashing-yellow night mode.
- Sits at the top of the intersection design; it is driven directly by car sensors, a pedestrian button and a mode switch.

---
 rtl/fanari_pkg.sv | 38 +++
 rtl/fanari_rr_arbiter.sv | 31 +++
 rtl/fanari_intersection.sv | 178 +++++++++++++++++
 tb/tb_fanari_intersection.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fanari_pkg.sv
// Shared types, default timing and parameter sanity helpers for the
// fanari intersection controller.
package fanari_pkg;

   typedef enum logic [2:0] {
      S_ALLRED,
      S_GREEN,
      S_YELLOW,
      S_WALK,
      S_FLASHING
   } state_t;

   localparam int DEF_N_DIR     = 4;
   localparam int DEF_CNT_W     = 8;
   localparam int DEF_T_GRN_MIN = 10;
   localparam int DEF_T_GRN_MAX = 30;
   localparam int DEF_T_YLW     = 3;
   localparam int DEF_T_ALLRED  = 2;
   localparam int DEF_T_WALK    = 8;
   localparam int DEF_T_FLASH   = 5;

   // A dwell of t cycles needs t-1 to be representable in the phase timer.
   function automatic bit fits_cnt(input int t, input int cnt_w);
      return (t >= 1) && (longint'(t) < (longint'(1) << cnt_w));
   endfunction

   function automatic bit params_ok(input int n_dir, input int cnt_w,
                                    input int t_grn_min, input int t_grn_max,
                                    input int t_ylw, input int t_allred,
                                    input int t_walk, input int t_flash);
      return (n_dir >= 2) && (n_dir <= 8) && (cnt_w >= 1) && (cnt_w <= 31) &&
             (t_grn_max >= t_grn_min) &&
             fits_cnt(t_grn_min, cnt_w) && fits_cnt(t_grn_max, cnt_w) &&
             fits_cnt(t_ylw, cnt_w) && fits_cnt(t_allred, cnt_w) &&
             fits_cnt(t_walk, cnt_w) && fits_cnt(t_flash, cnt_w);
   endfunction

endpackage

// File: rtl/fanari_rr_arbiter.sv
// Combinational round-robin pick: first requesting approach after cur,
// wrapping modulo N_DIR, with cur itself considered last.
module fanari_rr_arbiter #(
   parameter int N_DIR = 4,
   parameter int IDX_W = $clog2(N_DIR)
)(
   input  logic [N_DIR-1:0] req,
   input  logic [IDX_W-1:0] cur,
   output logic [IDX_W-1:0] grant,
   output logic             valid
);

   logic [IDX_W-1:0] idx;

   // NOTE: every variable written here gets a default first, otherwise the
   // paths where no request is found would infer latches.
   always_comb begin
      grant = '0;
      valid = 1'b0;
      idx   = '0;
      // Walk the distances from far to near so the nearest hit wins.
      for (int k = N_DIR; k >= 1; k--) begin
         idx = IDX_W'((int'(cur) + k) % N_DIR);
         if (req[idx]) begin
            grant = idx;
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/fanari_intersection.sv
// N-approach sensor-actuated traffic light controller with latched
// pedestrian all-red walk phase and flashing-yellow night mode.
module fanari_intersection
   import fanari_pkg::*;
#(
   parameter int N_DIR     = DEF_N_DIR,
   parameter int CNT_W     = DEF_CNT_W,
   parameter int T_GRN_MIN = DEF_T_GRN_MIN,
   parameter int T_GRN_MAX = DEF_T_GRN_MAX,
   parameter int T_YLW     = DEF_T_YLW,
   parameter int T_ALLRED  = DEF_T_ALLRED,
   parameter int T_WALK    = DEF_T_WALK,
   parameter int T_FLASH   = DEF_T_FLASH
)(
   input  logic             Clock,
   input  logic             Reset,
   input  logic [N_DIR-1:0] CAR,
   input  logic             PED_REQ,
   input  logic             FLASH,
   output logic [N_DIR-1:0] RED,
   output logic [N_DIR-1:0] YLW,
   output logic [N_DIR-1:0] GRN,
   output logic             WALK
);

   localparam int IDX_W = $clog2(N_DIR);

   localparam logic [CNT_W-1:0] ALLRED_END  = CNT_W'(T_ALLRED - 1);
   localparam logic [CNT_W-1:0] GRN_MIN_END = CNT_W'(T_GRN_MIN - 1);
   localparam logic [CNT_W-1:0] GRN_MAX_END = CNT_W'(T_GRN_MAX - 1);
   localparam logic [CNT_W-1:0] YLW_END     = CNT_W'(T_YLW - 1);
   localparam logic [CNT_W-1:0] WALK_END    = CNT_W'(T_WALK - 1);
   localparam logic [CNT_W-1:0] FLASH_END   = CNT_W'(T_FLASH - 1);

   if (!params_ok(N_DIR, CNT_W, T_GRN_MIN, T_GRN_MAX, T_YLW, T_ALLRED,
                  T_WALK, T_FLASH)) begin : g_param_check
      $error("fanari_intersection: illegal parameter set");
   end

   state_t           state, state_nx;
   logic [CNT_W-1:0] timer, timer_nx;
   logic [IDX_W-1:0] cur, cur_nx, pick;
   logic [N_DIR-1:0] pending, pending_nx;
   logic [N_DIR-1:0] cur_onehot, pick_onehot, car_mask, req, req_other;
   logic [N_DIR-1:0] red_nx, ylw_nx, grn_nx;
   logic             ped_pend, ped_pend_nx, pick_valid;
   logic             flash_on, flash_on_nx, walk_nx;
   logic             enter_green, enter_walk, demand;

   fanari_rr_arbiter #(.N_DIR(N_DIR), .IDX_W(IDX_W)) u_arb (
      .req   (req),
      .cur   (cur),
      .grant (pick),
      .valid (pick_valid)
   );

   // The approach being served in GREEN never latches its own request.
   always_comb begin
      cur_onehot       = '0;
      cur_onehot[cur]  = 1'b1;
      pick_onehot      = '0;
      pick_onehot[pick] = 1'b1;
      car_mask  = (state == S_GREEN) ? (CAR & ~cur_onehot) : CAR;
      req       = pending | car_mask;
      req_other = req & ~cur_onehot;
      demand    = (|req_other) || ped_pend;
   end

   always_comb begin
      state_nx = state;
      cur_nx   = cur;
      unique case (state)
         S_ALLRED: begin
            if (timer >= ALLRED_END) begin
               if (FLASH)           state_nx = S_FLASHING;
               else if (ped_pend)   state_nx = S_WALK;
               else if (pick_valid) begin
                  state_nx = S_GREEN;
                  cur_nx   = pick;
               end
            end
         end
         S_GREEN: begin
            if (FLASH)
               state_nx = S_YELLOW;
            else if (timer >= GRN_MIN_END && demand &&
                     (!CAR[cur] || timer >= GRN_MAX_END))
               state_nx = S_YELLOW;
         end
         S_YELLOW:   if (timer >= YLW_END)  state_nx = S_ALLRED;
         S_WALK:     if (timer >= WALK_END) state_nx = S_ALLRED;
         S_FLASHING: if (!FLASH)            state_nx = S_ALLRED;
         default:                           state_nx = S_ALLRED;
      endcase
   end

   always_comb begin
      enter_green = (state_nx == S_GREEN) && (state != S_GREEN);
      enter_walk  = (state_nx == S_WALK) && (state != S_WALK);
      pending_nx  = (pending | car_mask) & ~(enter_green ? pick_onehot : '0);
      ped_pend_nx = (ped_pend | PED_REQ) & ~enter_walk;

      // Idle all-red parks one cycle short of its end so a new request is
      // served on the very next edge.
      if (state_nx != state)
         timer_nx = '0;
      else if (state == S_ALLRED && timer >= ALLRED_END)
         timer_nx = ALLRED_END;
      else if (state == S_FLASHING && timer >= FLASH_END)
         timer_nx = '0;
      else if (timer != '1)
         timer_nx = timer + CNT_W'(1);
      else
         timer_nx = timer;

      if (state_nx != S_FLASHING)
         flash_on_nx = 1'b0;
      else if (state != S_FLASHING)
         flash_on_nx = 1'b1;
      else if (timer >= FLASH_END)
         flash_on_nx = ~flash_on;
      else
         flash_on_nx = flash_on;
   end

   // Lamps are decoded from the next state so they are registered alongside it.
   always_comb begin
      red_nx  = '1;
      ylw_nx  = '0;
      grn_nx  = '0;
      walk_nx = 1'b0;
      unique case (state_nx)
         S_GREEN: begin
            grn_nx[cur_nx] = 1'b1;
            red_nx[cur_nx] = 1'b0;
         end
         S_YELLOW: begin
            ylw_nx[cur_nx] = 1'b1;
            red_nx[cur_nx] = 1'b0;
         end
         S_WALK:     walk_nx = 1'b1;
         S_FLASHING: begin
            red_nx = '0;
            ylw_nx = {N_DIR{flash_on_nx}};
         end
         default: ;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state    <= S_ALLRED;
         timer    <= '0;
         cur      <= '0;
         pending  <= '0;
         ped_pend <= 1'b0;
         flash_on <= 1'b0;
         RED      <= '1;
         YLW      <= '0;
         GRN      <= '0;
         WALK     <= 1'b0;
      end else begin
         state    <= state_nx;
         timer    <= timer_nx;
         cur      <= cur_nx;
         pending  <= pending_nx;
         ped_pend <= ped_pend_nx;
         flash_on <= flash_on_nx;
         RED      <= red_nx;
         YLW      <= ylw_nx;
         GRN      <= grn_nx;
         WALK     <= walk_nx;
      end
   end

endmodule

// File: tb/tb_fanari_intersection.sv
// Self-checking bench for fanari_intersection: vector table, phase-timing
// sequences, and random traffic against a phase/age reference model.
module tb_fanari_intersection;

   localparam int N         = 4;
   localparam int T_GRN_MIN = 10;
   localparam int T_GRN_MAX = 30;
   localparam int T_YLW     = 3;
   localparam int T_ALLRED  = 2;
   localparam int T_WALK    = 8;
   localparam int T_FLASH   = 5;

   localparam logic [12:0] P_ALLRED   = {1'b0, 4'hF, 4'h0, 4'h0};
   localparam logic [12:0] P_WALK     = {1'b1, 4'hF, 4'h0, 4'h0};
   localparam logic [12:0] P_FLASH_ON = {1'b0, 4'h0, 4'hF, 4'h0};
   localparam logic [12:0] P_DARK     = 13'h0;

   logic         Clock, Reset, PED_REQ, FLASH;
   logic [N-1:0] CAR, RED, YLW, GRN;
   logic         WALK;
   logic [12:0]  lamps;

   assign lamps = {WALK, RED, YLW, GRN};

   fanari_intersection dut (
      .Clock   (Clock),
      .Reset   (Reset),
      .CAR     (CAR),
      .PED_REQ (PED_REQ),
      .FLASH   (FLASH),
      .RED     (RED),
      .YLW     (YLW),
      .GRN     (GRN),
      .WALK    (WALK)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: phase plus age (cycles the phase has been visible).
   typedef enum {M_RED, M_GO, M_AMBER, M_PED, M_NIGHT} m_phase_t;
   m_phase_t     m_phase = M_RED;
   int           m_age   = 1;
   int           m_cur   = 0;
   bit [N-1:0]   m_wait  = '0;
   bit           m_ped   = 1'b0;

   task automatic model_step(input bit rst, input logic [N-1:0] car, input bit ped, input bit flash);
      bit [N-1:0] seen, req, other;
      m_phase_t   nxt;
      int         pick;
      if (rst) begin
         m_phase = M_RED; m_age = 1; m_cur = 0; m_wait = '0; m_ped = 1'b0;
         return;
      end
      seen = car;
      if (m_phase == M_GO) seen[m_cur] = 1'b0;
      req   = m_wait | seen;
      other = req;
      other[m_cur] = 1'b0;
      pick = -1;
      for (int k = 1; k <= N; k++) begin
         if (pick < 0 && req[(m_cur + k) % N]) pick = (m_cur + k) % N;
      end
      nxt = m_phase;
      case (m_phase)
         M_RED: if (m_age >= T_ALLRED) begin
            if (flash)         nxt = M_NIGHT;
            else if (m_ped)    nxt = M_PED;
            else if (pick >= 0) nxt = M_GO;
         end
         M_GO: if (flash || (m_age >= T_GRN_MIN && (other != 0 || m_ped) &&
                             (!car[m_cur] || m_age >= T_GRN_MAX))) nxt = M_AMBER;
         M_AMBER: if (m_age >= T_YLW)  nxt = M_RED;
         M_PED:   if (m_age >= T_WALK) nxt = M_RED;
         M_NIGHT: if (!flash)          nxt = M_RED;
         default: nxt = M_RED;
      endcase
      m_wait = req;
      if (nxt == M_GO && m_phase != M_GO) begin
         m_wait[pick] = 1'b0;
         m_cur = pick;
      end
      m_ped = m_ped | ped;
      if (nxt == M_PED && m_phase != M_PED) m_ped = 1'b0;
      m_age   = (nxt != m_phase) ? 1 : m_age + 1;
      m_phase = nxt;
   endtask

   function automatic logic [12:0] m_lamps();
      logic [N-1:0] r, y, g;
      logic         w;
      r = '1; y = '0; g = '0; w = 1'b0;
      case (m_phase)
         M_GO:    begin g[m_cur] = 1'b1; r[m_cur] = 1'b0; end
         M_AMBER: begin y[m_cur] = 1'b1; r[m_cur] = 1'b0; end
         M_PED:   w = 1'b1;
         M_NIGHT: begin r = '0; y = (((m_age - 1) / T_FLASH) % 2 == 0) ? '1 : '0; end
         default: ;
      endcase
      return {w, r, y, g};
   endfunction

   function automatic logic [12:0] p_green(input int i);
      logic [N-1:0] oh;
      oh = '0; oh[i] = 1'b1;
      return {1'b0, ~oh, {N{1'b0}}, oh};
   endfunction

   function automatic logic [12:0] p_yellow(input int i);
      logic [N-1:0] oh;
      oh = '0; oh[i] = 1'b1;
      return {1'b0, ~oh, oh, {N{1'b0}}};
   endfunction

   // One clock: drive on the falling edge, step the model at the rising edge,
   // compare just after it.
   task automatic tick(input bit rst, input logic [N-1:0] car, input bit ped, input bit flash);
      @(negedge Clock);
      Reset = rst; CAR = car; PED_REQ = ped; FLASH = flash;
      @(posedge Clock);
      model_step(rst, car, ped, flash);
      #1;
      check("model", lamps, m_lamps());
   endtask

   task automatic count_run(input string name, input logic [12:0] pattern, input int start,
                            input int exp_len, input logic [N-1:0] car, input bit flash);
      int n = start;
      check({name, "_first"}, lamps, pattern);
      for (int i = 0; i < 100; i++) begin
         tick(1'b0, car, 1'b0, flash);
         if (lamps !== pattern) break;
         n++;
      end
      check(name, n, exp_len);
   endtask

   task automatic wait_for(input string name, input logic [12:0] pattern,
                           input logic [N-1:0] car, input int budget);
      bit found = 1'b0;
      for (int i = 0; i < budget && !found; i++) begin
         tick(1'b0, car, 1'b0, 1'b0);
         found = (lamps === pattern);
      end
      check(name, found, 1);
   endtask

   // Safety invariant monitor, sampled mid-cycle.
   bit           mon_on = 1'b0;
   logic [12:0]  prev   = P_ALLRED;
   logic [N-1:0] lit;

   always @(negedge Clock) begin
      if (mon_on) begin
         if (RED != '0) begin
            lit = GRN | YLW;
            check("inv_single_lamp", 32'($onehot0(lit)), 32'd1);
            check("inv_red_complement", 32'(RED == ~lit), 32'd1);
            if (WALK) check("inv_walk_clear", 32'(lit), 32'd0);
         end
         if (GRN != '0 && prev[N-1:0] == '0)
            check("inv_green_entry", 32'(prev), 32'(P_ALLRED));
      end
      prev = lamps;
   end

   typedef struct {
      string        name;
      int           reps;
      bit           rst;
      logic [N-1:0] car;
      bit           ped;
      bit           flash;
      logic [12:0]  exp;
   } vec_t;

   function automatic vec_t mk(input string name, input int reps, input bit rst,
                               input logic [N-1:0] car, input logic [12:0] exp);
      vec_t v;
      v.name = name; v.reps = reps; v.rst = rst; v.car = car;
      v.ped = 1'b0; v.flash = 1'b0; v.exp = exp;
      return v;
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t         vecs[$];
      logic [N-1:0] car;
      bit           fl;

      Reset = 1'b1; CAR = '0; PED_REQ = 1'b0; FLASH = 1'b0;

      vecs.push_back(mk("reset_hold",   3, 1'b1, 4'b0000, P_ALLRED));
      vecs.push_back(mk("idle_allred", 47, 1'b0, 4'b0000, P_ALLRED));
      vecs.push_back(mk("reset_again",  1, 1'b1, 4'b0000, P_ALLRED));
      vecs.push_back(mk("clearance_1",  1, 1'b0, 4'b0100, P_ALLRED));
      vecs.push_back(mk("green2_enter", 1, 1'b0, 4'b0100, p_green(2)));
      vecs.push_back(mk("green2_pulse", 1, 1'b0, 4'b0101, p_green(2)));
      vecs.push_back(mk("green2_min",   8, 1'b0, 4'b0000, p_green(2)));
      vecs.push_back(mk("yellow2",      3, 1'b0, 4'b0000, p_yellow(2)));
      vecs.push_back(mk("allred_2",     2, 1'b0, 4'b0000, P_ALLRED));
      vecs.push_back(mk("green0",       1, 1'b0, 4'b0000, p_green(0)));

      for (int v = 0; v < vecs.size(); v++) begin
         for (int r = 0; r < vecs[v].reps; r++) begin
            tick(vecs[v].rst, vecs[v].car, vecs[v].ped, vecs[v].flash);
            check(vecs[v].name, lamps, vecs[v].exp);
            mon_on = 1'b1;
         end
      end

      // Max-out: CAR[1] held, CAR[3] pulsed once during green 1.
      wait_for("reach_green1", p_green(1), 4'b0010, 40);
      tick(1'b0, 4'b1010, 1'b0, 1'b0);
      check("green1_pulse", lamps, p_green(1));
      count_run("green1_maxout", p_green(1), 2, T_GRN_MAX, 4'b0010, 1'b0);
      count_run("yellow1", p_yellow(1), 1, T_YLW, 4'b0000, 1'b0);
      count_run("allred_after1", P_ALLRED, 1, T_ALLRED, 4'b0000, 1'b0);
      check("green3_after_maxout", lamps, p_green(3));

      // Pedestrian request beats a car request at the same clearance exit.
      tick(1'b1, 4'b0000, 1'b0, 1'b0);
      tick(1'b0, 4'b0001, 1'b0, 1'b0);
      tick(1'b0, 4'b0001, 1'b0, 1'b0);
      check("green0_enter", lamps, p_green(0));
      for (int i = 0; i < 20; i++) tick(1'b0, 4'b0000, 1'b0, 1'b0);
      check("green0_resting", lamps, p_green(0));
      tick(1'b0, 4'b0100, 1'b1, 1'b0);
      count_run("ped_yellow0", p_yellow(0), 1, T_YLW, 4'b0000, 1'b0);
      count_run("ped_allred_a", P_ALLRED, 1, T_ALLRED, 4'b0000, 1'b0);
      count_run("walk_phase", P_WALK, 1, T_WALK, 4'b0000, 1'b0);
      count_run("ped_allred_b", P_ALLRED, 1, T_ALLRED, 4'b0000, 1'b0);
      check("green2_after_walk", lamps, p_green(2));

      // Night mode 4 cycles into green 2; CAR[3] latches while flashing.
      for (int i = 0; i < 3; i++) tick(1'b0, 4'b0000, 1'b0, 1'b0);
      tick(1'b0, 4'b0000, 1'b0, 1'b1);
      count_run("flash_yellow2", p_yellow(2), 1, T_YLW, 4'b0000, 1'b1);
      count_run("flash_allred", P_ALLRED, 1, T_ALLRED, 4'b0000, 1'b1);
      count_run("flash_on_a", P_FLASH_ON, 1, T_FLASH, 4'b1000, 1'b1);
      count_run("flash_off", P_DARK, 1, T_FLASH, 4'b0000, 1'b1);
      count_run("flash_on_b", P_FLASH_ON, 1, T_FLASH, 4'b0000, 1'b1);
      tick(1'b0, 4'b0000, 1'b0, 1'b0);
      count_run("night_exit_allred", P_ALLRED, 1, T_ALLRED, 4'b0000, 1'b0);
      check("green3_after_night", lamps, p_green(3));

      // Reset in the middle of yellow drops all latched requests.
      for (int i = 0; i < 12; i++) tick(1'b0, 4'b0000, 1'b0, 1'b0);
      tick(1'b0, 4'b0001, 1'b0, 1'b0);
      check("yellow3_a", lamps, p_yellow(3));
      tick(1'b0, 4'b0000, 1'b1, 1'b0);
      check("yellow3_b", lamps, p_yellow(3));
      tick(1'b1, 4'b0000, 1'b0, 1'b0);
      check("reset_mid_yellow", lamps, P_ALLRED);
      for (int i = 0; i < 10; i++) begin
         tick(1'b0, 4'b0000, 1'b0, 1'b0);
         check("reset_cleared", lamps, P_ALLRED);
      end

      // Random traffic against the reference model.
      fl = 1'b0;
      tick(1'b1, 4'b0000, 1'b0, 1'b0);
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(0, 299) == 0) fl = ~fl;
         for (int i = 0; i < N; i++) car[i] = ($urandom_range(0, 3) == 0);
         tick($urandom_range(0, 999) == 0, car, $urandom_range(0, 49) == 0, fl);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
